traceback_reader: RTL and testbench

- Reader side of the score/direction matrix filled by the Signal_manager fill path.
- After fill completes, it walks the stored direction symbols from cell (N,N) back to (0,0).
- At each step it fetches the sequence characters and emits one aligned pair per step, last pair first, over a valid/ready handshake.
- It sits between the direction/sequence RAMs and the alignment output buffer.

---
 rtl/traceback_reader.sv | 170 +++++++++++++++++
 tb/tb_traceback_reader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traceback_reader.sv
// Traceback walker for the alignment matrix: follows direction symbols
// from (N,N) to (0,0) and streams aligned pairs, last pair first.
module traceback_reader #(
    parameter int         N        = 128,
    parameter int         BitAddr  = $clog2(N + 1),
    parameter logic [2:0] GAP_CODE = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       symbol,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    output logic             en_read,
    output logic [BitAddr:0] i,
    output logic [BitAddr:0] j,
    output logic [BitAddr:0] addr_a,
    output logic [BitAddr:0] addr_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_a,
    output logic [2:0]       out_b,
    output logic [BitAddr:0] len,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int               W    = BitAddr + 1;
    localparam logic [BitAddr:0] NIDX = W'(N);
    localparam logic [BitAddr:0] ONE  = W'(1);

    localparam logic [2:0] DIAG = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] LEFT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [BitAddr:0] r_i;
    logic [BitAddr:0] r_j;
    logic [BitAddr:0] r_len;
    logic [2:0]       r_dir;
    logic [2:0]       r_out_a;
    logic [2:0]       r_out_b;
    logic             r_en_read;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic [2:0]       w_dir;
    logic             w_dir_ok;
    logic [BitAddr:0] w_i_nxt;
    logic [BitAddr:0] w_j_nxt;
    logic             w_read_nxt;

    // Edges of the matrix override the stored symbol so indices never underflow
    always_comb begin
        w_dir = symbol;
        if (r_i == '0) begin
            w_dir = LEFT;
        end else if (r_j == '0) begin
            w_dir = UP;
        end
        w_dir_ok = $onehot(w_dir);
    end

    always_comb begin
        w_i_nxt = r_i;
        w_j_nxt = r_j;
        if (r_dir[0] || r_dir[1]) begin
            w_i_nxt = r_i - ONE;
        end
        if (r_dir[0] || r_dir[2]) begin
            w_j_nxt = r_j - ONE;
        end
        w_read_nxt = (w_i_nxt != '0) || (w_j_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_len       <= '0;
            r_dir       <= DIAG;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_en_read   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_en_read <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i       <= NIDX;
                        r_j       <= NIDX;
                        r_len     <= '0;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_en_read <= (NIDX != '0);
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_i == '0 && r_j == '0) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (!w_dir_ok) begin
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_dir       <= w_dir;
                        r_out_a     <= (w_dir == LEFT) ? GAP_CODE : a;
                        r_out_b     <= (w_dir == UP) ? GAP_CODE : b;
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_i         <= w_i_nxt;
                        r_j         <= w_j_nxt;
                        r_len       <= r_len + ONE;
                        r_en_read   <= w_read_nxt;
                        r_state     <= S_READ;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign en_read   = r_en_read;
    assign i         = r_i;
    assign j         = r_j;
    assign addr_a    = (r_i == '0) ? '0 : r_i - ONE;
    assign addr_b    = (r_j == '0) ? '0 : r_j - ONE;
    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign len       = r_len;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_traceback_reader.sv
// Bench for traceback_reader: RAM model plus scoreboards for
// expected reads (i, j, len) and emitted pairs.
module tb_traceback_reader;

    localparam int         N   = 4;
    localparam int         BA  = $clog2(N + 1);
    localparam logic [2:0] GAP = 3'b111;
    localparam logic [2:0] D   = 3'b001;
    localparam logic [2:0] U   = 3'b010;
    localparam logic [2:0] L   = 3'b100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_ready;
    logic [2:0]    symbol = '0;
    logic [2:0]    a = '0;
    logic [2:0]    b = '0;
    logic          en_read;
    logic [BA:0]   i;
    logic [BA:0]   j;
    logic [BA:0]   addr_a;
    logic [BA:0]   addr_b;
    logic          out_valid;
    logic [2:0]    out_a;
    logic [2:0]    out_b;
    logic [BA:0]   len;
    logic          busy;
    logic          done;
    logic          error;

    logic [2:0]    sym_mem [0:N][0:N];
    logic [2:0]    a_mem [0:N-1];
    logic [2:0]    b_mem [0:N-1];

    int            n_chk = 0;
    int            n_err = 0;
    int            n_hs = 0;
    int            base;
    int            lat;
    logic [5:0]    q_pair [$];
    logic [11:0]   q_rd [$];
    logic [11:0]   e_rd;
    logic [5:0]    e_pr;
    logic [3:0]    e_addr;

    traceback_reader #(.N(N), .GAP_CODE(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .symbol    (symbol),
        .a         (a),
        .b         (b),
        .en_read   (en_read),
        .i         (i),
        .j         (j),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en_read) begin
            symbol <= sym_mem[i][j];
            a      <= a_mem[addr_a];
            b      <= b_mem[addr_b];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en_read) begin
            if (q_rd.size() == 0) begin
                check("rd_extra", q_rd.size(), 1);
            end else begin
                e_rd = q_rd.pop_front();
                check("rd_i", i, e_rd[11:8]);
                check("rd_j", j, e_rd[7:4]);
                check("rd_len", len, e_rd[3:0]);
                e_addr = (e_rd[11:8] == 4'd0) ? 4'd0 : e_rd[11:8] - 4'd1;
                check("addr_a", addr_a, e_addr);
                e_addr = (e_rd[7:4] == 4'd0) ? 4'd0 : e_rd[7:4] - 4'd1;
                check("addr_b", addr_b, e_addr);
            end
        end
        if (out_valid && out_ready && !rst) begin
            n_hs++;
            if (q_pair.size() == 0) begin
                check("pair_extra", q_pair.size(), 1);
            end else begin
                e_pr = q_pair.pop_front();
                check("pair", {out_a, out_b}, e_pr);
            end
        end
    end

    task automatic fill(input logic [2:0] s);
        for (int r = 0; r <= N; r++)
            for (int c = 0; c <= N; c++)
                sym_mem[r][c] = s;
    endtask

    task automatic set_seq(input int boff);
        for (int k = 0; k < N; k++) begin
            a_mem[k] = 3'(k);
            b_mem[k] = 3'(k + boff);
        end
    endtask

    task automatic push_rd(input int ii, input int jj, input int ll);
        q_rd.push_back({4'(ii), 4'(jj), 4'(ll)});
    endtask

    task automatic push_pr(input int pa, input int pb);
        q_pair.push_back({3'(pa), 3'(pb)});
    endtask

    task automatic push_diag(input int boff);
        for (int k = 0; k < N; k++) push_rd(N - k, N - k, k);
        for (int k = N - 1; k >= 0; k--) push_pr(k, k + boff);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done", done, 1);
        check("busy_end", busy, 0);
    endtask

    task automatic end_test();
        repeat (4) @(negedge clk);
        check("pair_left", q_pair.size(), 0);
        check("rd_left", q_rd.size(), 0);
    endtask

    task automatic check_reset();
        check("rst_i", i, 0);
        check("rst_j", j, 0);
        check("rst_len", len, 0);
        check("rst_en", en_read, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_oa", out_a, 0);
        check("rst_ob", out_b, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        fill(D);
        set_seq(0);
        repeat (2) @(posedge clk);
        #1 check_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // all diagonal, identical sequences
        push_diag(0);
        pulse_start();
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("first_lat", lat, 3);
        wait_done(60);
        check("t1_len", len, 4);
        check("t1_err", error, 0);
        end_test();

        // column N up, row 0 forced left (symbol there ignored)
        fill(D);
        set_seq(3);
        for (int r = 1; r <= N; r++) sym_mem[r][N] = U;
        for (int c = 0; c <= N; c++) sym_mem[0][c] = 3'b000;
        for (int k = 0; k < N; k++) push_rd(N - k, N, k);
        for (int k = 0; k < N; k++) push_rd(0, N - k, N + k);
        for (int k = N - 1; k >= 0; k--) push_pr(k, 7);
        for (int k = N - 1; k >= 0; k--) push_pr(7, k + 3);
        pulse_start();
        wait_done(100);
        check("t2_len", len, 8);
        check("t2_err", error, 0);
        end_test();

        // stall on the second pair
        fill(D);
        set_seq(3);
        push_diag(3);
        base = n_hs;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && n_hs == base + 1) break;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_a", out_a, 2);
            check("stall_b", out_b, 5);
            check("stall_i", i, 3);
            check("stall_j", j, 3);
            check("stall_len", len, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rel_len", len, 2);
        check("rel_valid", out_valid, 0);
        wait_done(60);
        check("t3_len", len, 4);
        end_test();

        // invalid symbol at (3,3)
        fill(D);
        set_seq(3);
        sym_mem[3][3] = 3'b011;
        push_rd(4, 4, 0);
        push_rd(3, 3, 1);
        push_pr(3, 6);
        pulse_start();
        wait_done(60);
        check("t4_err", error, 1);
        check("t4_len", len, 1);
        end_test();

        // mixed path with a real left and a forced up
        fill(D);
        set_seq(3);
        sym_mem[4][4] = L;
        sym_mem[4][3] = U;
        sym_mem[2][2] = L;
        sym_mem[1][0] = 3'b000;
        push_rd(4, 4, 0);
        push_rd(4, 3, 1);
        push_rd(3, 3, 2);
        push_rd(2, 2, 3);
        push_rd(2, 1, 4);
        push_rd(1, 0, 5);
        push_pr(7, 6);
        push_pr(3, 7);
        push_pr(2, 5);
        push_pr(7, 4);
        push_pr(1, 3);
        push_pr(0, 7);
        pulse_start();
        wait_done(80);
        check("t5_len", len, 6);
        check("t5_err", error, 0);
        end_test();

        // reset during third EMIT, with start held alongside rst
        fill(D);
        set_seq(3);
        push_diag(3);
        base = n_hs;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && n_hs == base + 2) break;
        end
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 check_reset();
        q_pair.delete();
        q_rd.delete();
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push_diag(3);
        pulse_start();
        wait_done(60);
        check("t6_len", len, 4);
        end_test();

        // start pulses while busy are ignored
        fill(D);
        set_seq(3);
        push_diag(3);
        base = n_hs;
        pulse_start();
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            start = busy && (n_hs == base + 1 || n_hs == base + 3);
            if (done) break;
        end
        start = 1'b0;
        check("t7_done", done, 1);
        check("t7_len", len, 4);
        end_test();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
